// File: rtl/perf_event_monitor.sv
// Performance-counter bank: counts cycles and event strobes, then freezes on halt and streams all counts out.
// rd_data is a combinational read; dump words move at one per cycle and hold stable while dump_ready is low.
module perf_event_monitor #(
  parameter int NUM_EVT  = 8,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1,
  parameter int IDX_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic [IDX_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [IDX_W-1:0]   dump_idx,
  output logic [CNT_W-1:0]   dump_data,
  output logic               frozen,
  output logic               done
);

  typedef enum logic [1:0] {ST_COUNT, ST_DUMP, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_EVT+1];
  logic [CNT_W-1:0]   cnt_d [NUM_EVT+1];
  logic [NUM_EVT:0]   ovf_q, ovf_d;
  logic               dump_valid_q, dump_valid_d;
  logic [IDX_W-1:0]   dump_idx_q, dump_idx_d;
  logic               frozen_q, frozen_d;
  logic               done_q, done_d;
  logic [NUM_EVT:0]   inc;

  // Slot NUM_EVT is the cycle counter, so it increments on every enabled cycle.
  assign inc = {1'b1, evt} & {(NUM_EVT+1){en}};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    frozen_d     = frozen_q;
    done_d       = done_q;
    case (state_q)
      ST_COUNT: begin
        if (clr) begin
          for (int i = 0; i <= NUM_EVT; i++) cnt_d[i] = '0;
          ovf_d = '0;
        end else begin
          for (int i = 0; i <= NUM_EVT; i++) begin
            if (inc[i]) begin
              if (cnt_q[i] == {CNT_W{1'b1}}) begin
                ovf_d[i] = 1'b1;
                cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
        end
        if (halt) begin
          state_d      = ST_DUMP;
          dump_valid_d = 1'b1;
          dump_idx_d   = '0;
          frozen_d     = 1'b1;
        end
      end
      ST_DUMP: begin
        if (dump_valid_q && dump_ready) begin
          if (dump_idx_q == IDX_W'(NUM_EVT)) begin
            state_d      = ST_DONE;
            dump_valid_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            dump_idx_d = dump_idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_COUNT;
      for (int i = 0; i <= NUM_EVT; i++) cnt_q[i] <= '0;
      ovf_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      frozen_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      frozen_q     <= frozen_d;
      done_q       <= done_d;
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_data   = '0;
    dump_data = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel == IDX_W'(i))     rd_data   = cnt_q[i];
      if (dump_idx_q == IDX_W'(i)) dump_data = cnt_q[i];
    end
  end

  assign ovf        = ovf_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign frozen     = frozen_q;
  assign done       = done_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: a 32-bit saturating bank plus two 8-bit banks for overflow behaviour.
module tb_perf_event_monitor;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } dw_t;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, halt, dump_ready;
  logic [7:0]  evt;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data, dump_data;
  logic [8:0]  ovf;
  logic        dump_valid, frozen, done;
  logic [3:0]  dump_idx;

  logic        s_en, s_clr;
  logic [7:0]  s_evt;
  logic [3:0]  s_sel;
  logic [7:0]  sat_rd, sat_dd, wrp_rd, wrp_dd;
  logic [8:0]  sat_ovf, wrp_ovf;
  logic        sat_dv, sat_fr, sat_dn, wrp_dv, wrp_fr, wrp_dn;
  logic [3:0]  sat_di, wrp_di;

  int errors = 0;
  int checks = 0;
  dw_t sb[$];
  dw_t exp_w;
  logic [0:5] rdy_pat;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EVT(8), .CNT_W(32), .SATURATE(1), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .evt(evt), .halt(halt),
    .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .frozen(frozen), .done(done));

  perf_event_monitor #(.NUM_EVT(8), .CNT_W(8), .SATURATE(1), .IDX_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(s_en), .clr(s_clr), .evt(s_evt), .halt(1'b0),
    .rd_sel(s_sel), .rd_data(sat_rd), .ovf(sat_ovf), .dump_valid(sat_dv),
    .dump_ready(1'b0), .dump_idx(sat_di), .dump_data(sat_dd),
    .frozen(sat_fr), .done(sat_dn));

  perf_event_monitor #(.NUM_EVT(8), .CNT_W(8), .SATURATE(0), .IDX_W(4)) dut_wrp (
    .clk(clk), .rst_n(rst_n), .en(s_en), .clr(s_clr), .evt(s_evt), .halt(1'b0),
    .rd_sel(s_sel), .rd_data(wrp_rd), .ovf(wrp_ovf), .dump_valid(wrp_dv),
    .dump_ready(1'b0), .dump_idx(wrp_di), .dump_data(wrp_dd),
    .frozen(wrp_fr), .done(wrp_dn));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] sel, input logic [31:0] exp, input string tag);
    rd_sel = sel;
    #1;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; halt = 1'b0; dump_ready = 1'b0;
    evt = '0; rd_sel = '0;
    s_en = 1'b0; s_clr = 1'b0; s_evt = '0; s_sel = 4'd3;
    step();
    do_reset();

    // Reset state
    chk("rst_valid", 64'(dump_valid), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rd(4'd8, 32'd0, "rst_cycles");

    // Plan 1: evt[0] and evt[2] for 10 cycles
    en = 1'b1; evt = 8'b0000_0101;
    repeat (10) step();
    en = 1'b0; evt = '0;
    rd(4'd0, 32'd10, "p1_cnt0");
    rd(4'd2, 32'd10, "p1_cnt2");
    rd(4'd1, 32'd0, "p1_cnt1");
    rd(4'd8, 32'd10, "p1_cycles");
    rd(4'd12, 32'd0, "p1_sel_oor");
    chk("p1_ovf", 64'(ovf), 64'd0);

    // Plan 2: 8-bit banks, 300 events on channel 3
    s_en = 1'b1; s_evt = 8'b0000_1000;
    repeat (300) step();
    s_en = 1'b0; s_evt = '0;
    s_sel = 4'd3; #1;
    chk("p2_sat_cnt3", 64'(sat_rd), 64'hFF);
    chk("p2_wrp_cnt3", 64'(wrp_rd), 64'd44);
    s_sel = 4'd8; #1;
    chk("p2_sat_cycles", 64'(sat_rd), 64'hFF);
    chk("p2_wrp_cycles", 64'(wrp_rd), 64'd44);
    chk("p2_sat_ovf", 64'(sat_ovf), 64'h108);
    chk("p2_wrp_ovf", 64'(wrp_ovf), 64'h108);
    s_clr = 1'b1; s_en = 1'b1; s_evt = 8'hFF;
    step();
    s_clr = 1'b0; s_en = 1'b0; s_evt = '0;
    chk("p2_clr_sat_ovf", 64'(sat_ovf), 64'd0);
    chk("p2_clr_wrp_ovf", 64'(wrp_ovf), 64'd0);
    chk("p2_clr_wrp_cycles", 64'(wrp_rd), 64'd0);

    // Plan 3: en toggling, then clr alongside an event
    clr = 1'b1; step(); clr = 1'b0;
    evt = 8'b0000_0001;
    en = 1'b1; step();
    en = 1'b0; step();
    en = 1'b1; step();
    en = 1'b0; step();
    rd(4'd0, 32'd2, "p3_cnt0");
    rd(4'd8, 32'd2, "p3_cycles");
    en = 1'b1; clr = 1'b1;
    step();
    en = 1'b0; clr = 1'b0; evt = '0;
    rd(4'd0, 32'd0, "p3_clr_cnt0");
    rd(4'd8, 32'd0, "p3_clr_cycles");
    chk("p3_clr_ovf", 64'(ovf), 64'd0);

    // Plan 4: preload counter i to i+1 and cycles to 50, then full-speed dump
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) evt[i] = (i >= k);
      step();
    end
    evt = '0;
    repeat (41) step();
    for (int i = 0; i < 8; i++) sb.push_back('{idx: 4'(i), data: 32'(i + 1)});
    sb.push_back('{idx: 4'd8, data: 32'd50});
    halt = 1'b1; dump_ready = 1'b1;
    step();
    chk("p4_frozen", 64'(frozen), 64'd1);
    for (int k = 0; k < 9; k++) begin
      evt = 8'($urandom);
      exp_w = sb.pop_front();
      chk("p4_valid", 64'(dump_valid), 64'd1);
      chk("p4_idx", 64'(dump_idx), 64'(exp_w.idx));
      chk("p4_data", 64'(dump_data), 64'(exp_w.data));
      step();
    end
    chk("p4_done", 64'(done), 64'd1);
    chk("p4_valid_off", 64'(dump_valid), 64'd0);
    chk("p4_frozen_done", 64'(frozen), 64'd1);
    rd(4'd5, 32'd6, "p4_cnt5_after");
    rd(4'd8, 32'd50, "p4_cycles_after");
    halt = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("p4_done_sticky", 64'(done), 64'd1);
    rd(4'd0, 32'd1, "p4_clr_ignored");

    // Plan 5: stalled dump, index 1 held for three cycles
    do_reset();
    en = 1'b1; evt = 8'hFF;
    repeat (3) step();
    halt = 1'b1;
    for (int i = 0; i < 9; i++) sb.push_back('{idx: 4'(i), data: 32'd4});
    step();
    halt = 1'b0; evt = '0;
    rdy_pat = 6'b100111;
    for (int c = 0; c < 6; c++) begin
      dump_ready = rdy_pat[c];
      chk("p5_valid", 64'(dump_valid), 64'd1);
      chk("p5_idx", 64'(dump_idx), 64'(sb[0].idx));
      chk("p5_data", 64'(dump_data), 64'(sb[0].data));
      step();
      if (rdy_pat[c]) exp_w = sb.pop_front();
    end
    chk("p6_idx_pre_rst", 64'(dump_idx), 64'd4);

    // Plan 6: reset mid-dump
    dump_ready = 1'b0;
    do_reset();
    sb.delete();
    chk("p6_valid", 64'(dump_valid), 64'd0);
    chk("p6_idx", 64'(dump_idx), 64'd0);
    chk("p6_frozen", 64'(frozen), 64'd0);
    chk("p6_done", 64'(done), 64'd0);
    chk("p6_ovf", 64'(ovf), 64'd0);
    rd(4'd0, 32'd0, "p6_cnt0");
    en = 1'b1; evt = 8'b0000_0001;
    repeat (3) step();
    en = 1'b0; evt = '0;
    rd(4'd0, 32'd3, "p6_resume_cnt0");
    rd(4'd8, 32'd3, "p6_resume_cycles");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
